mvm_16_1_8_1_core: RTL and testbench

- Signed matrix-vector multiplier computing y = A·x for a K×K matrix A and a K-element vector x; default K=16.
- Operands stream in one word per cycle on a shared input bus. Results stream out one word per cycle after a done pulse.
- One MAC lane (P=1) with a G-stage registered multiplier.
- Sits behind a host or sequencer that loads A and x, pulses start, then collects y[0..K-1].

---
 rtl/mvm_16_1_8_1_core.sv | 159 +++++++++++++++
 tb/tb_mvm_16_1_8_1_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mvm_16_1_8_1_core.sv
// Signed K x K matrix-vector multiplier, one MAC lane, G-stage product pipe.
// Define MVM_SATURATE_EN for saturating (sticky per row) accumulation.
module mvm_16_1_8_1_core #(
   parameter int K = 16,
   parameter int P = 1,
   parameter int B = 8,
   parameter int G = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  loadMatrix,
   input  logic                  loadVector,
   input  logic                  start,
   input  logic signed [B-1:0]   data_in,
   output logic                  done,
   output logic signed [2*B-1:0] data_out
);
   localparam int W  = 2 * B;
   localparam int NN = K * K;
   localparam int NI = NN / P;
   localparam int AW = $clog2(NN);
   localparam int RW = $clog2(K);
   localparam int CW = $clog2(NN + G + 1);

   localparam logic [CW-1:0] LAST_A = CW'(NN - 1);
   localparam logic [CW-1:0] LAST_X = CW'(K - 1);
   localparam logic [CW-1:0] LAST_C = CW'(NN + G);
   localparam logic [CW-1:0] N_ISS  = CW'(NI);

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT
   } state_t;

   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt;

   logic signed [B-1:0] r_a [NN];
   logic signed [B-1:0] r_x [K];
   logic signed [W-1:0] r_y [K];

   logic signed [W-1:0] r_pp [G];
   logic [RW-1:0]       r_pr [G];
   logic [G-1:0]        r_pv, r_pf, r_pl;
   logic signed [W-1:0] r_acc;

   logic                w_issue;
   logic [RW-1:0]       w_col, w_row;
   logic [AW-1:0]       w_aidx;
   logic signed [W-1:0] w_opa, w_opx, w_prod;
   logic signed [W-1:0] w_base, w_acc_next;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (loadMatrix)      w_next = LOAD_A;
            else if (loadVector) w_next = LOAD_X;
            else if (start)      w_next = COMPUTE;
         end
         LOAD_A:  if (r_cnt == LAST_A) w_next = IDLE;
         LOAD_X:  if (r_cnt == LAST_X) w_next = IDLE;
         COMPUTE: if (r_cnt == LAST_C) w_next = OUTPUT;
         OUTPUT:  if (r_cnt == LAST_X) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state || r_state == IDLE) r_cnt <= '0;
         else                                      r_cnt <= r_cnt + CW'(1);
      end
   end

   // Row-major walk: the low count bits are the column, the rest the row.
   assign w_issue = (r_state == COMPUTE) && (r_cnt < N_ISS);
   assign w_col   = r_cnt[RW-1:0];
   assign w_row   = r_cnt[AW-1:RW];
   assign w_aidx  = r_cnt[AW-1:0];
   assign w_opa   = {{B{r_a[w_aidx][B-1]}}, r_a[w_aidx]};
   assign w_opx   = {{B{r_x[w_col][B-1]}}, r_x[w_col]};
   assign w_prod  = w_opa * w_opx;

   assign w_base = r_pf[G-1] ? '0 : r_acc;

`ifdef MVM_SATURATE_EN
   logic                r_sat;
   logic                w_sat_next;
   logic signed [W:0]   w_ext;

   always_comb begin
      w_ext      = {w_base[W-1], w_base} + {r_pp[G-1][W-1], r_pp[G-1]};
      w_acc_next = w_ext[W-1:0];
      w_sat_next = 1'b0;
      if (r_sat && !r_pf[G-1]) begin
         w_acc_next = r_acc;
         w_sat_next = 1'b1;
      end else if (w_ext[W] != w_ext[W-1]) begin
         w_acc_next = w_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         w_sat_next = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_sat <= 1'b0;
      else if (r_pv[G-1]) r_sat <= w_sat_next;
   end
`else
   assign w_acc_next = w_base + r_pp[G-1];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pv  <= '0;
         r_pf  <= '0;
         r_pl  <= '0;
         r_acc <= '0;
         for (int g = 0; g < G; g++) begin
            r_pp[g] <= '0;
            r_pr[g] <= '0;
         end
      end else begin
         r_pv[0] <= w_issue;
         r_pf[0] <= (w_col == '0);
         r_pl[0] <= (w_col == RW'(K - 1));
         r_pp[0] <= w_prod;
         r_pr[0] <= w_row;
         for (int g = 1; g < G; g++) begin
            r_pv[g] <= r_pv[g-1];
            r_pf[g] <= r_pf[g-1];
            r_pl[g] <= r_pl[g-1];
            r_pp[g] <= r_pp[g-1];
            r_pr[g] <= r_pr[g-1];
         end
         if (r_pv[G-1]) r_acc <= w_acc_next;
      end
   end

   // Operand and result storage survives reset.
   always_ff @(posedge clk) begin
      if (r_state == LOAD_A) r_a[w_aidx] <= data_in;
      if (r_state == LOAD_X) r_x[w_col] <= data_in;
      if (r_pv[G-1] && r_pl[G-1]) r_y[r_pr[G-1]] <= w_acc_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done     <= 1'b0;
         data_out <= '0;
      end else begin
         done <= (r_state == COMPUTE) && (w_next == OUTPUT);
         if (r_state == OUTPUT) data_out <= r_y[w_col];
      end
   end
endmodule

// File: tb/tb_mvm_16_1_8_1_core.sv
// Scoreboard bench for mvm_16_1_8_1_core: directed vectors plus a few
// random sets checked against a behavioural y = A*x model.
module tb_mvm_16_1_8_1_core;
   localparam int K  = 16;
   localparam int NN = K * K;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              loadMatrix = 1'b0;
   logic              loadVector = 1'b0;
   logic              start = 1'b0;
   logic signed [7:0] data_in = '0;
   logic              done;
   logic signed [15:0] data_out;

   always #5 clk = ~clk;

   mvm_16_1_8_1_core dut (
      .clk        (clk),
      .reset      (reset),
      .loadMatrix (loadMatrix),
      .loadVector (loadVector),
      .start      (start),
      .done       (done),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   logic signed [7:0]  ta [NN];
   logic signed [7:0]  tx [K];
   logic signed [15:0] ey [K];
   logic signed [15:0] q [$];
   int errors = 0;
   int checks = 0;
   int ocnt = 0;

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name,
                  $signed(act), $signed(exp));
      end
   endtask

   // Monitor: done opens a K-word window; every word is popped and compared.
   always @(negedge clk) begin
      if (ocnt > 0) begin
         check("y_word", data_out, q.pop_front());
         check("done_in_output", {15'd0, done}, 16'd0);
         ocnt--;
      end else if (done) begin
         checks++;
         if (q.size() < K) begin
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pulse");
         end else begin
            ocnt = K;
         end
      end
   end

   task automatic load_a();
      @(negedge clk) loadMatrix = 1'b1;
      @(negedge clk) begin loadMatrix = 1'b0; data_in = ta[0]; end
      for (int n = 1; n < NN; n++) @(negedge clk) data_in = ta[n];
   endtask

   task automatic load_x();
      @(negedge clk) loadVector = 1'b1;
      @(negedge clk) begin loadVector = 1'b0; data_in = tx[0]; end
      for (int n = 1; n < K; n++) @(negedge clk) data_in = tx[n];
   endtask

   task automatic run();
      int n;
      for (int i = 0; i < K; i++) q.push_back(ey[i]);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while ((q.size() != 0 || ocnt != 0) && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || ocnt != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d words pending expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic model();
      int acc, p;
      bit sat;
      for (int r = 0; r < K; r++) begin
         acc = 0;
         sat = 0;
         for (int c = 0; c < K; c++) begin
            p = int'(ta[r*K+c]) * int'(tx[c]);
`ifdef MVM_SATURATE_EN
            if (!sat) begin
               acc = acc + p;
               if (acc > 32767) begin acc = 32767; sat = 1; end
               else if (acc < -32768) begin acc = -32768; sat = 1; end
            end
`else
            acc = acc + p;
`endif
         end
         ey[r] = 16'(acc);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic set_ident();
      for (int n = 0; n < NN; n++) ta[n] = (n / K == n % K) ? 8'sd1 : 8'sd0;
      for (int i = 0; i < K; i++) begin
         tx[i] = 8'(i);
         ey[i] = 16'(i);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset_done", {15'd0, done}, 16'd0);
      check("reset_data_out", data_out, 16'd0);
      @(negedge clk) reset = 1'b0;

      // Identity matrix, ramp vector
      set_ident();
      load_a();
      load_x();
      run();

      // Vector loaded before matrix
      for (int n = 0; n < NN; n++) ta[n] = 8'sd2;
      for (int i = 0; i < K; i++) begin tx[i] = 8'sd3; ey[i] = 16'sd96; end
      load_x();
      load_a();
      run();

      // Most negative operands: 16*16384 overflows 16 bits
      for (int n = 0; n < NN; n++) ta[n] = -8'sd128;
      for (int i = 0; i < K; i++) begin
         tx[i] = -8'sd128;
`ifdef MVM_SATURATE_EN
         ey[i] = 16'sd32767;
`else
         ey[i] = 16'sd0;
`endif
      end
      load_a();
      load_x();
      run();

      // Mixed signs: row r holds r-8
      for (int n = 0; n < NN; n++) ta[n] = 8'((n / K) - 8);
      for (int i = 0; i < K; i++) begin
         tx[i] = 8'sd1;
         ey[i] = 16'(16 * (i - 8));
      end
      load_a();
      load_x();
      run();

      // Start again without reloading reuses stored operands
      run();

      // Abort mid-compute: no done, data_out stays 0
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < K; i++) begin
         @(negedge clk);
         check("abort_data_out", data_out, 16'd0);
         check("abort_done", {15'd0, done}, 16'd0);
      end
      set_ident();
      load_a();
      load_x();
      run();

      // Random sets, each after a reset
      for (int s = 0; s < 4; s++) begin
         pulse_reset();
         for (int n = 0; n < NN; n++) ta[n] = 8'($urandom_range(0, 255));
         for (int i = 0; i < K; i++) tx[i] = 8'($urandom_range(0, 255));
         model();
         load_a();
         load_x();
         run();
      end

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
